// File: rtl/fifo_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_if
// Bundles the producer-side request bus and the FIFO write port that the
// round-robin FIFO write arbiter sits between.
//
//   req         producers -> arbiter   per-producer request
//   req_data    producers -> arbiter   producer i word on [i*DATA_WIDTH +: DATA_WIDTH]
//   ack         arbiter -> producers   one-hot, word of producer i written this cycle
//   fifo_full   FIFO -> arbiter        FIFO full flag
//   fifo_w_en   arbiter -> FIFO        write enable
//   fifo_wdata  arbiter -> FIFO        write data (zero when fifo_w_en is low)
//   grant_valid arbiter -> observers   an owner is currently granted
//   grant_id    arbiter -> observers   index of the current owner
//
// Modports: master = arbiter side, slave = environment (producers + FIFO).
// ---------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned DATA_WIDTH = 4
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            ack;
  logic                          fifo_full;
  logic                          fifo_w_en;
  logic [DATA_WIDTH-1:0]         fifo_wdata;
  logic                          grant_valid;
  logic [ID_WIDTH-1:0]           grant_id;

  modport master (
    input  req, req_data, fifo_full,
    output ack, fifo_w_en, fifo_wdata, grant_valid, grant_id
  );

  modport slave (
    output req, req_data, fifo_full,
    input  ack, fifo_w_en, fifo_wdata, grant_valid, grant_id
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter sharing one synchronous FIFO write port among up to
// NUM_REQ producers. The write path (fifo_w_en, fifo_wdata, ack) is
// combinational from the registered owner and the live req/fifo_full, so a
// word is only ever acked in the same cycle it is written into the FIFO.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous reset, active-high
//   bus  fifo_wr_arbiter_if.master (req, req_data, fifo_full in;
//        ack, fifo_w_en, fifo_wdata, grant_valid, grant_id out)
//
// Configuration macro: FIFO_ARB_BURST_EN
//   defined   - an owner keeps the port for up to BURST_LEN words
//   undefined - ownership rotates after every word, BURST_LEN is ignored
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic               clk,
  input  logic               rst,
  fifo_wr_arbiter_if.master  bus
);

  // req widened to every value grant_id can encode so owner indexes it exactly
  localparam int unsigned NSLOT = 2**ID_WIDTH;

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t               state;
  logic [ID_WIDTH-1:0]  owner;
  logic [ID_WIDTH-1:0]  last;

`ifdef FIFO_ARB_BURST_EN
  localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  logic [CNT_W-1:0]     burst_cnt;
  logic                 burst_last;
`endif

  logic [NSLOT-1:0]      req_ext;
  logic                  owner_req;
  logic                  xfer;
  logic                  release_now;
  logic                  pick_idle_vld;
  logic [ID_WIDTH-1:0]   pick_idle;
  logic                  pick_rel_vld;
  logic [ID_WIDTH-1:0]   pick_rel;
  logic [DATA_WIDTH-1:0] owner_data;
  logic [NUM_REQ-1:0]    ack_vec;

  // First requester at or after 'start' (mod NUM_REQ). MSB of result = found.
  function automatic logic [ID_WIDTH:0] rr_pick(
    input logic [NSLOT-1:0] r,
    input int unsigned      start
  );
    logic [ID_WIDTH:0]   res;
    logic [ID_WIDTH-1:0] idx;
    res = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ID_WIDTH'((start + k) % NUM_REQ);
      if (!res[ID_WIDTH] && r[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  assign req_ext   = NSLOT'(bus.req);
  assign owner_req = req_ext[owner];

  // Searching from last+1 (IDLE) or owner+1 (release) puts the previous owner
  // at the end of the scan, so it wins again only as the sole requester.
  assign {pick_idle_vld, pick_idle} = rr_pick(req_ext, 32'(last) + 32'd1);
  assign {pick_rel_vld,  pick_rel}  = rr_pick(req_ext, 32'(owner) + 32'd1);

  assign xfer = (state == S_GRANT) && owner_req && !bus.fifo_full;

`ifdef FIFO_ARB_BURST_EN
  assign burst_last  = (burst_cnt == CNT_W'(BURST_LEN - 1));
  assign release_now = (state == S_GRANT) && ((xfer && burst_last) || !owner_req);
`else
  assign release_now = (state == S_GRANT) && (xfer || !owner_req);
`endif

  always_comb begin
    owner_data = '0;
    ack_vec    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner == ID_WIDTH'(i)) begin
        owner_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        ack_vec[i] = xfer;
      end
    end
  end

  assign bus.fifo_w_en   = xfer;
  assign bus.fifo_wdata  = xfer ? owner_data : '0;
  assign bus.ack         = ack_vec;
  assign bus.grant_valid = (state == S_GRANT);
  assign bus.grant_id    = owner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      owner <= '0;
      last  <= ID_WIDTH'(NUM_REQ - 1);
`ifdef FIFO_ARB_BURST_EN
      burst_cnt <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_idle_vld) begin
            owner <= pick_idle;
            state <= S_GRANT;
`ifdef FIFO_ARB_BURST_EN
            burst_cnt <= '0;
`endif
          end
        end
        S_GRANT: begin
          if (release_now) begin
            last <= owner;
`ifdef FIFO_ARB_BURST_EN
            burst_cnt <= '0;
`endif
            if (pick_rel_vld) begin
              owner <= pick_rel;
            end else begin
              state <= S_IDLE;
            end
          end
`ifdef FIFO_ARB_BURST_EN
          else if (xfer) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one synchronous FIFO write port among up to NUM_REQ producers. It sits directly in front of the FIFO. It drives the FIFO's write enable and write data, and observes the FIFO full flag. Each granted producer may write a burst of up to BURST_LEN words before ownership rotates. The write path is combinational from the granted producer, so a full FIFO never loses a word.

## Interface
- NUM_REQ, 4, number of producers (2..4)
- ID_WIDTH, 2, width of grant_id; NUM_REQ <= 2**ID_WIDTH
- DATA_WIDTH, 4, word width; equals the FIFO's MEMORY_WIDTH
- BURST_LEN, 4, maximum words per grant (>= 1)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- req  in  NUM_REQ  per-producer request; held high while the producer has a word on its data slice
- req_data  in  NUM_REQ*DATA_WIDTH  producer i's word on bits [i*DATA_WIDTH +: DATA_WIDTH]
- fifo_full  in  1  FIFO full flag
- fifo_w_en  out  1  FIFO write enable
- fifo_wdata  out  DATA_WIDTH  FIFO write data
- ack  out  NUM_REQ  one-hot; bit i high means producer i's word is written this cycle
- grant_valid  out  1  an owner is currently granted
- grant_id  out  ID_WIDTH  index of the current owner

## Operation
- Registered state: fsm (IDLE, GRANT), owner, last (last owner), burst_cnt.
- IDLE:
  - If any req is high, select the first requester searching from (last+1) mod NUM_REQ upward with wrap.
  - Load owner with that requester, clear burst_cnt, go to GRANT.
- GRANT:
  - xfer = req[owner] & !fifo_full.
  - fifo_w_en = xfer. fifo_wdata = req_data slice of owner. ack = xfer << owner.
  - On xfer, burst_cnt increments.
  - Release at the edge when either:
    - xfer and burst_cnt == BURST_LEN-1, or
    - req[owner] is low.
  - On release: last <= owner. If any other req is high, pick the next owner round-robin from owner+1 and stay in GRANT with burst_cnt cleared. Otherwise go to IDLE.
  - fifo_full high: no xfer, burst_cnt holds, no release while req[owner] stays high.
- Release round-robin search uses the current req vector and may select the same owner only when it is the sole requester.
- fifo_wdata is forced to zero whenever fifo_w_en is low.
- grant_valid = (fsm == GRANT). grant_id = owner.
- Requests for indices >= NUM_REQ do not exist. Out-of-range owner values are unreachable.

## Timing
- Reset values:
  - fsm IDLE, owner 0, last NUM_REQ-1, burst_cnt 0.
  - Outputs: fifo_w_en 0, fifo_wdata 0, ack 0, grant_valid 0, grant_id 0.
  - From reset, requester 0 wins first.
- Latency: req rising in IDLE gives first write the following cycle (1 cycle arbitration).
- Back-to-back handoff in GRANT costs no idle cycle. The new owner can write the cycle after release.
- Handshake: a producer advances its word only on its ack bit. It must hold req and data stable until acked.
- fifo_full is sampled combinationally in the same cycle. A write is never issued while full is high.
- Simultaneous release and new request: the new request participates in the same-edge selection.
- Reset mid-burst: all state clears asynchronously, and fifo_w_en and ack drop immediately. A partially written burst is not resumed. The producer re-requests.

## Configuration
- FIFO_ARB_BURST_EN defined: burst hold as described, up to BURST_LEN words per grant.
- Undefined: BURST_LEN is ignored and treated as 1. Ownership rotates after every transferred word. burst_cnt logic is removed.

## Test plan
- Reset, then req=4'b0001 with data 4'hA, fifo_full=0 -> grant_valid at cycle 1, fifo_w_en=1 with fifo_wdata=4'hA and ack=4'b0001 at cycle 1.
- Burst mode, req=4'b0011 held, data 4'h1/4'h2 -> four writes of 4'h1 (ack 0001), then four of 4'h2 (ack 0010), alternating with no gap cycles.
- Macro undefined, same stimulus -> writes alternate 4'h1, 4'h2, 4'h1, 4'h2 each cycle.
- Owner 2 mid-burst, fifo_full=1 for 3 cycles -> fifo_w_en=0, ack=0, grant_id stays 2, burst_cnt frozen; burst completes its remaining words after full drops.
- req=4'b1111 continuously -> grant order 0,1,2,3,0; each producer receives BURST_LEN acks per round.
- rst asserted while owner=1 with burst_cnt=2 -> fifo_w_en and ack go 0 immediately; after release with req=4'b0010, owner 1 restarts with a full burst from burst_cnt=0.
